// File: rtl/dm_hart_ctrl.sv
// Per-hart run control for the debug module: halt/resume handshakes,
// halt-request timeout, havereset tracking and dmstatus/haltsum0 summaries.
module dm_hart_ctrl #(
    parameter int unsigned        NrHarts         = 4,
    parameter logic [NrHarts-1:0] SelectableHarts = {NrHarts{1'b1}},
    parameter int unsigned        HaltTimeout     = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dmactive_i,
    input  logic [19:0]        hartsel_i,
    input  logic               hasel_i,
    input  logic [NrHarts-1:0] hawindow_i,
    input  logic               haltreq_i,
    input  logic               resumereq_i,
    input  logic               ackhavereset_i,
    input  logic [NrHarts-1:0] halted_i,
    input  logic [NrHarts-1:0] resuming_i,
    input  logic [NrHarts-1:0] unavailable_i,
    input  logic [NrHarts-1:0] hart_reset_i,
    output logic [NrHarts-1:0] debug_req_o,
    output logic               anyhalted_o,
    output logic               allhalted_o,
    output logic               anyrunning_o,
    output logic               allrunning_o,
    output logic               anyresumeack_o,
    output logic               allresumeack_o,
    output logic               anyhavereset_o,
    output logic               allhavereset_o,
    output logic               anyunavail_o,
    output logic               allunavail_o,
    output logic               anynonexistent_o,
    output logic               allnonexistent_o,
    output logic [31:0]        haltsum0_o,
    output logic [NrHarts-1:0] halt_timeout_o,
    output logic               busy_o
);

    localparam int unsigned    CntW   = (HaltTimeout < 1) ? 1 : $clog2(HaltTimeout + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(HaltTimeout);

    typedef enum logic [1:0] {
        RUNNING    = 2'd0,
        HALT_REQ   = 2'd1,
        HALTED     = 2'd2,
        RESUME_REQ = 2'd3
    } state_e;

    // dmactive low behaves exactly like reset
    logic clr;
    assign clr = rst_i | ~dmactive_i;

    logic [NrHarts-1:0] onehot;
    logic [NrHarts-1:0] sel;
    logic [NrHarts-1:0] halted_st;
    logic [NrHarts-1:0] running_st;
    logic [NrHarts-1:0] busy_st;
    logic [NrHarts-1:0] resumeack;
    logic [NrHarts-1:0] havereset;
    logic [NrHarts-1:0] unavail;

    // hart selection: hartsel one-hot plus optional hart-array window
    always_comb begin
        onehot = '0;
        if (hartsel_i < 20'(NrHarts)) begin
            onehot = NrHarts'(1) << hartsel_i;
        end
        sel = (onehot | (hasel_i ? hawindow_i : '0)) & SelectableHarts;
    end

    for (genvar i = 0; i < NrHarts; i++) begin : g_hart
        if (SelectableHarts[i]) begin : g_sel
            state_e          state_q;
            logic [CntW-1:0] cnt_q;
            logic            dreq_q;
            logic            tmo_q;
            logic            rack_q;
            logic            hrst_q;

            // run-control FSM with registered debug request and timeout flag
            always_ff @(posedge clk_i) begin
                if (clr) begin
                    state_q <= RUNNING;
                    cnt_q   <= '0;
                    dreq_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                    rack_q  <= 1'b0;
                end else begin
                    case (state_q)
                        RUNNING: begin
                            if (halted_i[i]) begin
                                state_q <= HALTED;
                                tmo_q   <= 1'b0;
                            end else if (haltreq_i && sel[i]) begin
                                state_q <= HALT_REQ;
                                cnt_q   <= '0;
                                dreq_q  <= 1'b1;
                            end
                        end
                        HALT_REQ: begin
                            if (halted_i[i]) begin
                                state_q <= HALTED;
                                cnt_q   <= '0;
                                dreq_q  <= 1'b0;
                                tmo_q   <= 1'b0;
                            end else if (!haltreq_i) begin
                                state_q <= RUNNING;
                                cnt_q   <= '0;
                                dreq_q  <= 1'b0;
                            end else begin
                                if (cnt_q != CntMax) begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                                // flag lands on the edge where the count reaches HaltTimeout
                                if ((cnt_q == CntMax - 1'b1) || (cnt_q == CntMax)) begin
                                    tmo_q <= 1'b1;
                                end
                            end
                        end
                        HALTED: begin
                            if (!halted_i[i]) begin
                                state_q <= RUNNING;
                            end else if (resumereq_i && sel[i] && !haltreq_i) begin
                                state_q <= RESUME_REQ;
                                rack_q  <= 1'b0;
                            end
                        end
                        RESUME_REQ: begin
                            if (resuming_i[i]) begin
                                state_q <= RUNNING;
                                rack_q  <= 1'b1;
                            end
                        end
                        default: state_q <= RUNNING;
                    endcase
                end
            end

            // havereset: hart reset pulse wins over an acknowledge in the same cycle
            always_ff @(posedge clk_i) begin
                if (clr) begin
                    hrst_q <= 1'b1;
                end else if (hart_reset_i[i]) begin
                    hrst_q <= 1'b1;
                end else if (ackhavereset_i && sel[i]) begin
                    hrst_q <= 1'b0;
                end
            end

            assign debug_req_o[i]    = dreq_q;
            assign halt_timeout_o[i] = tmo_q;
            assign resumeack[i]      = rack_q;
            assign havereset[i]      = hrst_q;
            assign unavail[i]        = unavailable_i[i];
            assign halted_st[i]      = (state_q == HALTED) & ~unavailable_i[i];
            assign running_st[i]     = ((state_q == RUNNING) | (state_q == RESUME_REQ)) & ~unavailable_i[i];
            assign busy_st[i]        = (state_q == HALT_REQ) | (state_q == RESUME_REQ);
        end else begin : g_nosel
            assign debug_req_o[i]    = 1'b0;
            assign halt_timeout_o[i] = 1'b0;
            assign resumeack[i]      = 1'b0;
            assign havereset[i]      = 1'b0;
            assign unavail[i]        = 1'b0;
            assign halted_st[i]      = 1'b0;
            assign running_st[i]     = 1'b0;
            assign busy_st[i]        = 1'b0;
        end
    end

    function automatic logic all_of(input logic [NrHarts-1:0] s, input logic [NrHarts-1:0] x);
        return (s != '0) && ((s & x) == s);
    endfunction

    assign anyhalted_o      = |(sel & halted_st);
    assign allhalted_o      = all_of(sel, halted_st);
    assign anyrunning_o     = |(sel & running_st);
    assign allrunning_o     = all_of(sel, running_st);
    assign anyresumeack_o   = |(sel & resumeack);
    assign allresumeack_o   = all_of(sel, resumeack);
    assign anyhavereset_o   = |(sel & havereset);
    assign allhavereset_o   = all_of(sel, havereset);
    assign anyunavail_o     = |(sel & unavail);
    assign allunavail_o     = all_of(sel, unavail);
    assign anynonexistent_o = ((onehot & SelectableHarts) == '0);
    assign allnonexistent_o = anynonexistent_o;
    assign busy_o           = |busy_st;

    // haltsum0: one bit per group of 32 harts, groups past NrHarts are zero-padded
    logic [1023:0] halted_pad;
    assign halted_pad = 1024'(halted_st);
    for (genvar j = 0; j < 32; j++) begin : g_hsum
        assign haltsum0_o[j] = |halted_pad[32*j +: 32];
    end

endmodule
